acq_sequencer: RTL

- Normal-clock-domain controller that sequences the acquisition datapath: fast-domain/FIFO reset, clock-generator lock wait, settle, run, stop and stall handling.
- Shadows SPI-written config (clock select, divisor, channel enables) so multi-bit synchronizers into the fast domain only ever see values that are stable while acquisition runs.
- Sits between the SPI register file and the normal-to-fast synchronizers, and drives the status LED.

---
 rtl/acq_pkg.sv | 24 ++
 rtl/acq_sequencer_if.sv | 38 +++
 rtl/acq_led_driver.sv | 33 +++
 rtl/acq_sequencer.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/acq_pkg.sv
// Shared types and constants for the acquisition sequencer: state encoding,
// config field widths and the power-on channel mask.
package acq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RESET  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_RUN    = 3'd3,
        ST_STALL  = 3'd4,
        ST_ERROR  = 3'd5
    } acq_state_t;

    localparam int CFG_DIV_W  = 8;
    localparam int CFG_CHAN_W = 16;

    localparam logic [CFG_CHAN_W-1:0] DEFAULT_CHAN_MASK = 16'hFFFF;

    // States in which the fast domain and its FIFOs must be held in reset.
    function automatic logic holds_fast_reset(input acq_state_t s);
        return (s == ST_IDLE) || (s == ST_RESET) || (s == ST_ERROR);
    endfunction

endpackage

// File: rtl/acq_sequencer_if.sv
// Command/config inputs from the register file and the sequencer's outputs
// toward the normal-to-fast synchronizers and the status LED.
interface acq_sequencer_if;
    import acq_pkg::*;

    logic                  cmd_start;
    logic                  cmd_stop;
    logic                  cfg_clock_select;
    logic [CFG_DIV_W-1:0]  cfg_clock_divisor;
    logic [CFG_CHAN_W-1:0] cfg_channel_enable;
    logic                  clocks_locked;
    logic                  fifo_overflow;

    logic                  acq_reset;
    logic                  acq_enable;
    logic                  clock_select;
    logic [CFG_DIV_W-1:0]  clock_divisor;
    logic [CFG_CHAN_W-1:0] channel_enable;
    logic [2:0]            state;
    logic                  stalled;
    logic                  lock_error;
    logic                  led_out;

    modport master (
        output cmd_start, cmd_stop, cfg_clock_select, cfg_clock_divisor,
               cfg_channel_enable, clocks_locked, fifo_overflow,
        input  acq_reset, acq_enable, clock_select, clock_divisor,
               channel_enable, state, stalled, lock_error, led_out
    );

    modport slave (
        input  cmd_start, cmd_stop, cfg_clock_select, cfg_clock_divisor,
               cfg_channel_enable, clocks_locked, fifo_overflow,
        output acq_reset, acq_enable, clock_select, clock_divisor,
               channel_enable, state, stalled, lock_error, led_out
    );

endinterface

// File: rtl/acq_led_driver.sv
// Status LED: solid for bring-up/error, slow blink while running,
// fast blink while stalled, off when idle.
module acq_led_driver
    import acq_pkg::*;
#(
    parameter int LED_DIV_BITS = 22
) (
    input  logic       clk,
    input  logic       rst,
    input  acq_state_t state,
    output logic       led_out
);

    logic [LED_DIV_BITS-1:0] blink_cnt;

    // state is the sequencer's next state, so led_out lines up with the
    // registered state output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt <= '0;
            led_out   <= 1'b0;
        end else begin
            blink_cnt <= blink_cnt + LED_DIV_BITS'(1);
            case (state)
                ST_IDLE:  led_out <= 1'b0;
                ST_RUN:   led_out <= blink_cnt[LED_DIV_BITS-1];
                ST_STALL: led_out <= blink_cnt[LED_DIV_BITS-3];
                default:  led_out <= 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/acq_sequencer.sv
// Acquisition sequencer: fast-domain reset, lock wait, settle, run/stall
// control, with config shadowed so the fast-domain synchronizers see stable values.
//
// state  | meaning
// IDLE   | fast domain held in reset, waiting for cmd_start
// RESET  | reset held >= RESET_CYCLES and until clocks lock (or timeout)
// SETTLE | reset released, waiting SETTLE_CYCLES before enabling
// RUN    | acquisition enabled
// STALL  | FIFO overflowed, fast domain holds buffered data for readout
// ERROR  | lock lost or never achieved, fast domain held in reset
module acq_sequencer
    import acq_pkg::*;
#(
    parameter int RESET_CYCLES  = 16,
    parameter int SETTLE_CYCLES = 32,
    parameter int LOCK_TIMEOUT  = 65535,
    parameter int LED_DIV_BITS  = 22
) (
    input logic            clk,
    input logic            rst,
    acq_sequencer_if.slave bus
);

    localparam int CNT_MAX = (RESET_CYCLES > SETTLE_CYCLES) ? RESET_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam int TMO_W   = $clog2(LOCK_TIMEOUT + 1);

    // Loaded with N-1 so a phase occupies exactly N cycles including its last.
    localparam logic [CNT_W-1:0] RESET_LOAD  = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST    = TMO_W'(LOCK_TIMEOUT - 1);

    acq_state_t            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [TMO_W-1:0]      tmo_q, tmo_d;
    logic                  stalled_q, stalled_d;
    logic                  lock_err_q, lock_err_d;
    logic                  shadow_load;
    logic                  acq_reset_q;
    logic                  acq_enable_q;
    logic                  clock_select_q;
    logic [CFG_DIV_W-1:0]  clock_divisor_q;
    logic [CFG_CHAN_W-1:0] channel_enable_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            cnt_q            <= '0;
            tmo_q            <= '0;
            stalled_q        <= 1'b0;
            lock_err_q       <= 1'b0;
            acq_reset_q      <= 1'b1;
            acq_enable_q     <= 1'b0;
            clock_select_q   <= 1'b0;
            clock_divisor_q  <= '0;
            channel_enable_q <= DEFAULT_CHAN_MASK;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tmo_q        <= tmo_d;
            stalled_q    <= stalled_d;
            lock_err_q   <= lock_err_d;
            acq_reset_q  <= holds_fast_reset(state_d);
            acq_enable_q <= (state_d == ST_RUN);
            if (shadow_load) begin
                clock_select_q   <= bus.cfg_clock_select;
                clock_divisor_q  <= bus.cfg_clock_divisor;
                channel_enable_q <= bus.cfg_channel_enable;
            end
        end
    end

    // Stop beats start; either command pre-empts the per-state rules.
    always_comb begin
        state_d     = state_q;
        cnt_d       = (cnt_q == '0) ? cnt_q : cnt_q - CNT_W'(1);
        tmo_d       = tmo_q;
        stalled_d   = stalled_q;
        lock_err_d  = lock_err_q;
        shadow_load = 1'b0;
        if (bus.cmd_stop) begin
            state_d = ST_IDLE;
        end else if (bus.cmd_start) begin
            state_d     = ST_RESET;
            cnt_d       = RESET_LOAD;
            tmo_d       = '0;
            stalled_d   = 1'b0;
            lock_err_d  = 1'b0;
            shadow_load = 1'b1;
        end else begin
            case (state_q)
                ST_RESET: begin
                    tmo_d = tmo_q + TMO_W'(1);
                    // Lock arriving on the last allowed cycle still wins over the timeout.
                    if (cnt_q == '0 && bus.clocks_locked) begin
                        state_d = ST_SETTLE;
                        cnt_d   = SETTLE_LOAD;
                    end else if (tmo_q == TMO_LAST) begin
                        state_d    = ST_ERROR;
                        lock_err_d = 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (!bus.clocks_locked) begin
                        state_d = ST_RESET;
                        cnt_d   = RESET_LOAD;
                        tmo_d   = '0;
                    end else if (cnt_q == '0) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (bus.fifo_overflow) begin
                        state_d   = ST_STALL;
                        stalled_d = 1'b1;
                    end else if (!bus.clocks_locked) begin
                        state_d    = ST_ERROR;
                        lock_err_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    acq_led_driver #(
        .LED_DIV_BITS (LED_DIV_BITS)
    ) u_led (
        .clk     (clk),
        .rst     (rst),
        .state   (state_d),
        .led_out (bus.led_out)
    );

    assign bus.state          = state_q;
    assign bus.acq_reset      = acq_reset_q;
    assign bus.acq_enable     = acq_enable_q;
    assign bus.clock_select   = clock_select_q;
    assign bus.clock_divisor  = clock_divisor_q;
    assign bus.channel_enable = channel_enable_q;
    assign bus.stalled        = stalled_q;
    assign bus.lock_error     = lock_err_q;

endmodule
